// File: rtl/absorb_sequencer.sv
// Absorb sequencer: slices a byte-length-tagged message into rate-sized word
// blocks for padding_generator, appending zero pad words to complete the block.
module absorb_sequencer #(
  parameter int W              = 64,
  parameter int LEN_WIDTH      = 32,
  parameter int RATE_WORDS_128 = 21,
  parameter int RATE_WORDS_256 = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LEN_WIDTH-1:0] msg_len,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [W-1:0]         word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [2:0]           valid_word_bytes,
  output logic                 padding_enable,
  output logic                 last_word_in_block,
  output logic                 padding_reset,
  output logic                 block_done,
  output logic                 msg_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MSG  = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0]           RATE_128       = 5'(RATE_WORDS_128);
  localparam logic [4:0]           RATE_256       = 5'(RATE_WORDS_256);
  localparam logic [LEN_WIDTH-1:0] BYTES_PER_WORD = LEN_WIDTH'(8);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO       = {LEN_WIDTH{1'b0}};

  logic [1:0]           state_r;
  logic [4:0]           rate_r;
  logic [4:0]           wcnt_r;
  logic [4:0]           wcnt_next_s;
  logic [LEN_WIDTH-1:0] rem_r;
  logic [LEN_WIDTH-1:0] rem_next_s;
  logic                 tail_s;
  logic                 last_s;
  logic                 xfer_s;

  // Output decode from the current state; din passes straight through in MSG.
  always_comb begin
    din_ready        = 1'b0;
    word_out         = {W{1'b0}};
    word_valid       = 1'b0;
    valid_word_bytes = 3'd0;
    padding_enable   = 1'b0;
    padding_reset    = 1'b0;
    msg_done         = 1'b0;
    last_s           = 1'b0;
    tail_s           = (rem_r < BYTES_PER_WORD);
    case (state_r)
      S_IDLE: begin
        padding_reset = start;
      end
      S_MSG: begin
        word_out   = din;
        word_valid = din_valid;
        din_ready  = word_ready;
        last_s     = (wcnt_r == rate_r - 5'd1);
        if (tail_s) begin
          padding_enable   = 1'b1;
          valid_word_bytes = rem_r[2:0];
        end else begin
          padding_enable   = 1'b0;
          valid_word_bytes = 3'd0;
        end
      end
      S_PAD: begin
        word_valid     = 1'b1;
        padding_enable = 1'b1;
        last_s         = (wcnt_r == rate_r - 5'd1);
      end
      S_DONE: begin
        msg_done      = 1'b1;
        padding_reset = start;
      end
      default: begin
        word_out = {W{1'b0}};
      end
    endcase
    xfer_s             = word_valid & word_ready;
    last_word_in_block = last_s;
    block_done         = xfer_s & last_s;
    rem_next_s         = tail_s ? LEN_ZERO : (rem_r - BYTES_PER_WORD);
    wcnt_next_s        = last_s ? 5'd0 : (wcnt_r + 5'd1);
  end

  // Sequencing state: block position, remaining bytes and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      rate_r  <= RATE_128;
      wcnt_r  <= 5'd0;
      rem_r   <= LEN_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            rate_r  <= mode ? RATE_256 : RATE_128;
            rem_r   <= msg_len;
            wcnt_r  <= 5'd0;
            state_r <= (msg_len != LEN_ZERO) ? S_MSG : S_PAD;
          end
        end
        S_MSG: begin
          if (xfer_s) begin
            rem_r  <= rem_next_s;
            wcnt_r <= wcnt_next_s;
            // A padded tail landing on the block's last word closes the message;
            // otherwise (including exact multiples of 8) pad words follow.
            if (rem_next_s == LEN_ZERO) begin
              state_r <= (last_s && padding_enable) ? S_DONE : S_PAD;
            end
          end
        end
        S_PAD: begin
          if (xfer_s) begin
            wcnt_r <= wcnt_next_s;
            if (last_s) begin
              state_r <= S_DONE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_sequencer.sv
// Scoreboard bench for absorb_sequencer: a closed-form model of the word
// sequence is queued at start and popped as the DUT transfers words.
module tb_absorb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] msg_len;
  logic [63:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  valid_word_bytes;
  logic        padding_enable;
  logic        last_word_in_block;
  logic        padding_reset;
  logic        block_done;
  logic        msg_done;

  typedef struct {
    logic [63:0] w;
    logic        pe;
    logic [2:0]  vwb;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  absorb_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .msg_len(msg_len),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .valid_word_bytes(valid_word_bytes), .padding_enable(padding_enable),
    .last_word_in_block(last_word_in_block), .padding_reset(padding_reset),
    .block_done(block_done), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {word_valid, din_ready, padding_enable, last_word_in_block,
                             padding_reset, block_done, msg_done, valid_word_bytes}, 64'd0);
    check_eq({tag, "_word"}, word_out, 64'd0);
  endtask

  // Runs one message; abort_after > 0 asserts rst after that many transfers.
  task automatic run_msg(input logic m, input int len, input bit stall_en,
                         input bit gap_en, input int abort_after);
    int          rate  = m ? 17 : 21;
    int          nw    = (len + 7) / 8;
    int          extra = (len % 8 == 0) ? 1 : 0;
    int          total = ((nw + extra + rate - 1) / rate) * rate;
    logic [63:0] words[$];
    int          din_idx = 0;
    int          xfers = 0;
    int          accepts = 0;
    bit          done = 0;
    bit          aborted = 0;
    bit          held = 0;
    bit          acc;
    bit          prev_stall = 0;
    logic [63:0] prev_w = 64'd0;
    logic [5:0]  prev_ctl = 6'd0;
    exp_t        e;

    for (int i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
    for (int i = 0; i < total; i++) begin
      e.w    = (i < nw) ? words[i] : 64'd0;
      e.pe   = (i >= nw) || ((i == nw - 1) && (len % 8 != 0));
      e.vwb  = ((i == nw - 1) && (len % 8 != 0)) ? 3'(len % 8) : 3'd0;
      e.last = ((i % rate) == rate - 1);
      sb.push_back(e);
    end

    start = 1'b1; mode = m; msg_len = 32'(len); din_valid = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    check_eq("prst_start", padding_reset, 1'b1);
    check_eq("start_wvalid", word_valid, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      word_ready = stall_en ? (cyc % 2 == 0) : 1'b1;
      if (din_idx < nw) begin
        din       = words[din_idx];
        din_valid = held ? 1'b1 : (gap_en ? (cyc % 3 != 2) : 1'b1);
      end else begin
        din       = {$urandom, $urandom};
        din_valid = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) check_eq("prst_clear", padding_reset, 1'b0);
      if (prev_stall) begin
        check_eq("stall_valid", word_valid, 1'b1);
        check_eq("stall_word", word_out, prev_w);
        check_eq("stall_ctl", {padding_enable, valid_word_bytes, last_word_in_block, 1'b0}, prev_ctl);
      end
      if (word_valid && word_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra_xfer", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("word_out", word_out, e.w);
          check_eq("pad_en", padding_enable, e.pe);
          check_eq("vwb", valid_word_bytes, e.vwb);
          check_eq("last_in_blk", last_word_in_block, e.last);
          check_eq("block_done", block_done, e.last);
        end
        xfers++;
      end
      acc = din_valid && din_ready;
      if (acc) accepts++;
      prev_stall = word_valid && !word_ready;
      prev_w     = word_out;
      prev_ctl   = {padding_enable, valid_word_bytes, last_word_in_block, 1'b0};
      if (msg_done) begin
        done = 1;
        break;
      end
      if (abort_after > 0 && xfers == abort_after) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      if (acc) din_idx++;
      held = din_valid && !acc;
    end

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      check_all_zero("rst_idle");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_rst_idle");
      @(posedge clk); #1;
      sb.delete();
    end else begin
      check_eq("timeout", done, 1'b1);
      check_eq("sb_left", sb.size(), 0);
      check_eq("din_accepts", accepts, nw);
      check_eq("xfers", xfers, total);
      check_eq("done_ctl", {word_valid, din_ready, padding_enable, last_word_in_block,
                            block_done, valid_word_bytes}, 64'd0);
      @(posedge clk); #1;
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; msg_len = 32'd0;
    din = 64'hDEAD_BEEF_0123_4567; din_valid = 1'b1; word_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");
    @(posedge clk); #1;

    run_msg(1'b0, 5,   1'b0, 1'b0, 0);
    run_msg(1'b0, 168, 1'b0, 1'b0, 0);
    run_msg(1'b0, 167, 1'b0, 1'b0, 0);
    run_msg(1'b1, 0,   1'b0, 1'b0, 0);
    run_msg(1'b1, 40,  1'b1, 1'b1, 0);
    run_msg(1'b0, 100, 1'b0, 1'b0, 3);
    run_msg(1'b0, 8,   1'b0, 1'b0, 0);
    run_msg(1'b1, 13,  1'b1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
